snoop_bus_ctrl: RTL and testbench

Parametrised snooping-bus controller for NCPU private caches sharing one memory.
- Arbitrates cache miss/upgrade requests round-robin.
- Broadcasts the winning transaction to all snoopers and collects shared/dirty responses.
- Sources data either from the dirty owner (writing it back to memory, no memory read issued) or from memory.
- Sits between the per-CPU cache controllers and the memory block, replacing the fixed 3-CPU bus/machine-bus muxing with a handshake-driven engine.

---
 rtl/snoop_pkg.sv | 28 ++
 rtl/snoop_bus_ctrl_rr_arbiter.sv | 33 +++
 rtl/snoop_bus_ctrl.sv | 158 +++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_pkg.sv
// rtl/snoop_pkg.sv - shared types and helpers for the snooping-bus controller
package snoop_pkg;

  typedef enum logic [1:0] {
    CMD_ILL  = 2'b00,
    CMD_RD   = 2'b01,
    CMD_RDX  = 2'b10,
    CMD_UPGR = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    BCAST,
    SNOOP,
    WB,
    MEMRD,
    DONE
  } state_t;

  // Index of the lowest set bit (0 when none set); wide enough for NCPU up to 8.
  function automatic int lowest_set(input logic [7:0] v);
    lowest_set = 0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = i;
    end
  endfunction

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// rtl/snoop_bus_ctrl_rr_arbiter.sv - round-robin arbiter starting at a pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic found;
  int   j;

  // Scan requesters starting at ptr, wrapping once; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[IW'(j)]) begin
        found          = 1'b1;
        grant[IW'(j)]  = 1'b1;
        idx            = IW'(j);
      end
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// rtl/snoop_bus_ctrl.sv - snooping-bus transaction engine for NCPU private caches
module snoop_bus_ctrl
  import snoop_pkg::*;
#(
  parameter int NCPU = 4,
  parameter int AW   = 5,
  parameter int DW   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCPU-1:0]         req,
  input  logic [2*NCPU-1:0]       req_cmd,
  input  logic [AW*NCPU-1:0]      req_addr,
  output logic [NCPU-1:0]         gnt,
  output logic                    bus_valid,
  output logic [1:0]              bus_cmd,
  output logic [AW-1:0]           bus_addr,
  output logic [$clog2(NCPU)-1:0] bus_src,
  input  logic [NCPU-1:0]         snp_shared,
  input  logic [NCPU-1:0]         snp_dirty,
  input  logic [DW*NCPU-1:0]      snp_data,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  input  logic [DW-1:0]           mem_rdata,
  input  logic                    mem_ack,
  output logic [NCPU-1:0]         done,
  output logic [DW-1:0]           rsp_data,
  output logic                    rsp_shared,
  output logic                    err
);

  localparam int IW = $clog2(NCPU);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, win_q;
  cmd_t            cmd_q;
  logic [AW-1:0]   addr_q;
  logic            shared_q;
  logic [DW-1:0]   data_q;

  logic [NCPU-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic [NCPU-1:0] win_oh, masked_shared, masked_dirty;
  logic [IW-1:0]   owner_idx;
  logic [DW-1:0]   owner_data;

  rr_arbiter #(.N(NCPU)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // The requester never snoops itself, so its own responses are masked off.
  assign win_oh        = NCPU'(1) << win_q;
  assign masked_shared = snp_shared & ~win_oh;
  assign masked_dirty  = snp_dirty & ~win_oh;
  assign owner_idx     = IW'(lowest_set(8'(masked_dirty)));
  assign owner_data    = snp_data[owner_idx*DW +: DW];

  // State register plus the per-transaction context latched along the way.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cmd_q    <= CMD_ILL;
      addr_q   <= '0;
      shared_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|arb_grant) begin
            win_q    <= arb_idx;
            cmd_q    <= cmd_t'(req_cmd[arb_idx*2 +: 2]);
            addr_q   <= req_addr[arb_idx*AW +: AW];
            shared_q <= 1'b0;
            data_q   <= '0;
            ptr_q    <= (int'(arb_idx) == NCPU-1) ? '0 : arb_idx + 1'b1;
          end
        end
        SNOOP: begin
          shared_q <= |masked_shared;
          if (cmd_q != CMD_UPGR && |masked_dirty) data_q <= owner_data;
        end
        MEMRD: begin
          if (mem_ack) data_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode; everything is zero outside its own state.
  always_comb begin
    state_d    = state_q;
    gnt        = '0;
    bus_valid  = 1'b0;
    bus_cmd    = 2'b00;
    bus_addr   = '0;
    bus_src    = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    done       = '0;
    rsp_data   = '0;
    rsp_shared = 1'b0;
    err        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_grant) state_d = BCAST;
      end
      BCAST: begin
        gnt = win_oh;
        if (cmd_q == CMD_ILL) begin
          err     = 1'b1;
          state_d = DONE;
        end else begin
          bus_valid = 1'b1;
          bus_cmd   = cmd_q;
          bus_addr  = addr_q;
          bus_src   = win_q;
          state_d   = SNOOP;
        end
      end
      SNOOP: begin
        err = $countones(masked_dirty) > 1;
        if (cmd_q == CMD_UPGR)  state_d = DONE;
        else if (|masked_dirty) state_d = WB;
        else                    state_d = MEMRD;
      end
      WB: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        if (mem_ack) state_d = DONE;
      end
      MEMRD: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) state_d = DONE;
      end
      DONE: begin
        done       = win_oh;
        rsp_data   = data_q;
        rsp_shared = shared_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb/tb_snoop_bus_ctrl.sv - self-checking bench for snoop_bus_ctrl
module tb_snoop_bus_ctrl;

  localparam int NCPU = 4;
  localparam int AW   = 5;
  localparam int DW   = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NCPU-1:0]   req;
  logic [2*NCPU-1:0] req_cmd;
  logic [AW*NCPU-1:0] req_addr;
  logic [NCPU-1:0]   gnt;
  logic              bus_valid;
  logic [1:0]        bus_cmd;
  logic [AW-1:0]     bus_addr;
  logic [1:0]        bus_src;
  logic [NCPU-1:0]   snp_shared, snp_dirty;
  logic [DW*NCPU-1:0] snp_data;
  logic              mem_rd, mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic              mem_ack;
  logic [NCPU-1:0]   done;
  logic [DW-1:0]     rsp_data;
  logic              rsp_shared;
  logic              err;

  snoop_bus_ctrl #(.NCPU(NCPU), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
    .gnt(gnt), .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_src(bus_src),
    .snp_shared(snp_shared), .snp_dirty(snp_dirty), .snp_data(snp_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .done(done), .rsp_data(rsp_data), .rsp_shared(rsp_shared), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: pending requests per CPU and the round-robin pointer.
  int          ptr_m;
  bit [NCPU-1:0] pend;
  logic [1:0]  pcmd  [NCPU];
  logic [AW-1:0] paddr [NCPU];
  bit          after_done;

  // Directed-scenario overrides.
  bit          dir, rereq, abort_mem;
  logic [3:0]  d_shared, d_dirty;
  logic [31:0] d_data;
  int          d_k;
  logic [7:0]  d_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {21'd0, gnt, bus_valid, bus_cmd, bus_addr, bus_src, mem_rd, mem_wr, mem_addr,
            mem_wdata, done, rsp_data, rsp_shared, err};
  endfunction

  task automatic drive_req();
    req = pend;
    for (int i = 0; i < NCPU; i++) begin
      req_cmd[i*2 +: 2]   = pcmd[i];
      req_addr[i*AW +: AW] = paddr[i];
    end
  endtask

  task automatic garbage_snoop();
    snp_shared = 4'($urandom);
    snp_dirty  = 4'($urandom);
    snp_data   = $urandom;
  endtask

  task automatic set_req(input int cpu, input logic [1:0] c, input logic [AW-1:0] a);
    pend[cpu]  = 1'b1;
    pcmd[cpu]  = c;
    paddr[cpu] = a;
  endtask

  task automatic do_txn();
    int w, it, exp_it, k, owner, nd;
    bit legal, wb, got_g, exp_shared;
    logic [1:0]  c;
    logic [AW-1:0] a;
    logic [3:0]  sh, dy, md;
    logic [31:0] sd;
    logic [7:0]  exp_rsp, rd;

    w = -1;
    for (int i = 0; i < NCPU; i++) begin
      int jj;
      jj = (ptr_m + i) % NCPU;
      if (w < 0 && pend[jj]) w = jj;
    end
    if (w < 0) begin
      check("no_pending", 0, 1);
      return;
    end
    exp_it = after_done ? 2 : 1;
    drive_req();

    got_g = 0;
    it = 0;
    while (!got_g && it < 8) begin
      @(negedge clock);
      it++;
      if (gnt != 0) got_g = 1;
    end
    check("gnt_seen", 64'(got_g), 1);
    check("idle_gap", 64'(it), 64'(exp_it));
    check("gnt", 64'(gnt), 64'(1 << w));
    c = pcmd[w];
    a = paddr[w];
    legal = (c != 2'b00);
    check("bus_valid", 64'(bus_valid), 64'(legal));
    check("err_bcast", 64'(err), 64'(!legal));
    if (legal) check("bus_word", 64'({bus_cmd, bus_addr, bus_src}), 64'({c, a, 2'(w)}));
    ptr_m = (w + 1) % NCPU;

    pend[w] = rereq;
    if (!dir) begin
      for (int i = 0; i < NCPU; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          set_req(i, ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3)), AW'($urandom));
    end
    drive_req();

    if (dir) begin
      sh = d_shared; dy = d_dirty; sd = d_data;
    end else begin
      sh = 4'($urandom); dy = 4'($urandom & $urandom); sd = $urandom;
    end
    snp_shared = sh;
    snp_dirty  = dy;
    snp_data   = sd;
    exp_rsp    = 8'h00;
    exp_shared = 1'b0;

    if (legal) begin
      @(negedge clock);
      md = dy & ~4'(1 << w);
      nd = 0;
      for (int i = 0; i < NCPU; i++) nd += int'(md[i]);
      check("err_snoop", 64'(err), 64'(nd > 1));
      check("snoop_quiet", 64'({gnt, bus_valid, mem_rd, mem_wr, done}), 0);
      exp_shared = |(sh & ~4'(1 << w));
      if (c != 2'b11) begin
        wb = (md != 0);
        owner = 0;
        for (int i = NCPU-1; i >= 0; i--) if (md[i]) owner = i;
        if (wb) exp_rsp = sd[owner*8 +: 8];
        k = dir ? d_k : $urandom_range(0, 3);
        for (int cyc = 0; cyc <= k; cyc++) begin
          @(negedge clock);
          if (cyc == 0) garbage_snoop();
          check("mem_rd", 64'(mem_rd), 64'(!wb));
          check("mem_wr", 64'(mem_wr), 64'(wb));
          check("mem_addr", 64'(mem_addr), 64'(a));
          if (wb) check("mem_wdata", 64'(mem_wdata), 64'(exp_rsp));
          check("done_early", 64'(done), 0);
          if (abort_mem) begin
            #2 reset = 1'b1;
            #1 check("reset_outs", all_outs(), 0);
            mem_ack = 1'b0;
            @(negedge clock);
            check("reset_hold", all_outs(), 0);
            reset = 1'b0;
            ptr_m = 0;
            after_done = 0;
            pend = '0;
            drive_req();
            return;
          end
          if (cyc == k) begin
            rd = dir ? d_rdata : 8'($urandom);
            mem_ack   = 1'b1;
            mem_rdata = rd;
            if (!wb) exp_rsp = rd;
          end
        end
      end
    end

    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    garbage_snoop();
    check("done", 64'(done), 64'(1 << w));
    check("rsp_data", 64'(rsp_data), 64'(exp_rsp));
    check("rsp_shared", 64'(rsp_shared), 64'(exp_shared));
    check("done_quiet", 64'({mem_rd, mem_wr, err, gnt}), 0);
    after_done = 1;
  endtask

  initial begin
    reset = 1'b0;
    pend = '0;
    for (int i = 0; i < NCPU; i++) begin
      pcmd[i] = 2'b00;
      paddr[i] = '0;
    end
    drive_req();
    snp_shared = '0; snp_dirty = '0; snp_data = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    dir = 1; rereq = 0; abort_mem = 0;
    d_shared = '0; d_dirty = '0; d_data = '0; d_k = 0; d_rdata = '0;
    ptr_m = 0; after_done = 0;
    #1 reset = 1'b1;
    #2 check("reset_state", all_outs(), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("idle_state", all_outs(), 0);

    // CPU1 BusRd, no snoop hits, memory fill 0x5A.
    set_req(1, 2'b01, 5'd8);
    d_shared = 4'b0000; d_dirty = 4'b0000; d_k = 2; d_rdata = 8'h5A;
    do_txn();

    // CPU0 BusRd, CPU2 dirty owner supplies 0x3C and writes back.
    set_req(0, 2'b01, 5'd12);
    d_shared = 4'b0100; d_dirty = 4'b0100; d_data = 32'h003C0000; d_k = 1;
    do_txn();

    // CPU3 BusUpgr with CPU1 sharing: no memory, shortest path.
    set_req(3, 2'b11, 5'd14);
    d_shared = 4'b0010; d_dirty = 4'b0000;
    do_txn();

    // All four requesting continuously: fair rotation.
    for (int i = 0; i < NCPU; i++) set_req(i, 2'b11, AW'(i + 1));
    d_shared = 4'b0000; d_dirty = 4'b0000; rereq = 1;
    for (int n = 0; n < 5; n++) do_txn();
    rereq = 0;
    pend = '0;

    // CPU0 BusRdX, two dirty snoopers: lowest (CPU1) wins, err pulses.
    set_req(0, 2'b10, 5'd3);
    d_shared = 4'b1010; d_dirty = 4'b1010; d_data = 32'h33221100; d_k = 0;
    do_txn();

    // Requester's own dirty/shared bits are ignored.
    set_req(0, 2'b01, 5'd5);
    d_shared = 4'b0001; d_dirty = 4'b0001; d_k = 1; d_rdata = 8'h77;
    do_txn();

    // Illegal command: grant, err, straight to done.
    set_req(2, 2'b00, 5'd9);
    d_shared = 4'b1111; d_dirty = 4'b1011;
    do_txn();

    // Randomized traffic against the model.
    dir = 0;
    for (int n = 0; n < 60; n++) begin
      if (pend == '0) set_req($urandom_range(0, NCPU-1), 2'($urandom_range(1, 3)), AW'($urandom));
      do_txn();
    end
    while (pend != '0) do_txn();

    // Reset in the middle of a memory read, then pointer restarts at 0.
    dir = 1;
    set_req(1, 2'b01, 5'd7);
    d_shared = 4'b0000; d_dirty = 4'b0000; d_k = 2; d_rdata = 8'hEE;
    abort_mem = 1;
    do_txn();
    abort_mem = 0;
    set_req(0, 2'b01, 5'd4);
    set_req(2, 2'b01, 5'd10);
    d_k = 1; d_rdata = 8'hA5;
    do_txn();
    d_rdata = 8'h5C;
    do_txn();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
